// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - received-word delivery handshake between uart_rx_ctrl and its consumer
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_ready, frame_err, parity_err, overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_ready, frame_err, parity_err, overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame FSM driven by an external bit rate pulse generator
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_in,
  input  logic           end_half_time,
  input  logic           end_bit_time,
  output logic           bit_en,
  output logic           busy,
  uart_rx_ctrl_if.master rx_if
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] ABORT  = 3'd5;

  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
  localparam logic       ODD      = (PARITY_ODD != 0);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 par_calc;

  assign rx_s     = sync_q[1];
  assign bit_en   = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign par_calc = (^shift_q) ^ par_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;

    if (rx_if.rx_ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was noise; let the bit finish so the count wraps.
        if (end_half_time && rx_s) begin
          state_d = ABORT;
        end else if (end_bit_time) begin
          state_d = DATA;
          idx_d   = 4'd0;
        end
      end
      ABORT: begin
        if (end_bit_time) state_d = IDLE;
      end
      DATA: begin
        if (end_half_time) shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        if (end_bit_time) begin
          if (idx_q == LAST_IDX) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      PARITY: begin
        if (end_half_time) par_d   = rx_s;
        if (end_bit_time)  state_d = STOP;
      end
      STOP: begin
        // Commit overrides a same-cycle ack: the new word stays ready and no overrun is flagged.
        if (end_half_time) begin
          data_d  = shift_q;
          ferr_d  = ~rx_s;
          perr_d  = (PARITY_EN != 0) ? (par_calc ^ ODD) : 1'b0;
          ovr_d   = ovr_d | (ready_q & ~rx_if.rx_ack);
          ready_d = 1'b1;
        end
        if (end_bit_time) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      idx_q   <= 4'd0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_ready   = ready_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl, lane 0 is 8N1 and lane 1 is 8E1
module tb_uart_rx_ctrl;

  localparam int N = 11;

  typedef struct {
    logic [7:0] d;
    bit         r;
    bit         f;
    bit         p;
    bit         o;
    int         dur;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] rx_line = 2'b11;
  logic [1:0] ack = 2'b00;

  wire [1:0]      bit_en_w, busy_w, rdy_w, ferr_w, perr_w, ovr_w;
  wire [1:0][7:0] data_w;

  int npass = 0;
  int ntot  = 0;

  exp_t       exp_q[2][$];
  bit   [1:0] m_rdy, m_ovr, m_ferr, m_perr;
  logic [7:0] m_data[2];

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [3:0] cnt;
    wire        half = bit_en_w[g] && (cnt == 4'(N / 2));
    wire        endb = bit_en_w[g] && (cnt == 4'(N - 1));

    // Bit rate pulse generator model: counts only while enabled, holds otherwise.
    always @(posedge clk) begin
      if (!rst)             cnt <= 4'd0;
      else if (bit_en_w[g]) cnt <= (cnt == 4'(N - 1)) ? 4'd0 : cnt + 4'd1;
    end

    uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();
    assign bus.rx_ack = ack[g];
    assign data_w[g]  = bus.rx_data;
    assign rdy_w[g]   = bus.rx_ready;
    assign ferr_w[g]  = bus.frame_err;
    assign perr_w[g]  = bus.parity_err;
    assign ovr_w[g]   = bus.overrun;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(g), .PARITY_ODD(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_in        (rx_line[g]),
      .end_half_time(half),
      .end_bit_time (endb),
      .bit_en       (bit_en_w[g]),
      .busy         (busy_w[g]),
      .rx_if        (bus)
    );

    initial begin : monitor
      int   dur;
      bit   prev;
      exp_t e;
      dur  = 0;
      prev = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          dur  = 0;
          prev = 1'b0;
        end else begin
          if (busy_w[g]) begin
            dur++;
          end else if (prev) begin
            if (exp_q[g].size() == 0) begin
              chk($sformatf("lane%0d_unexpected_frame", g), 1, 0);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("lane%0d_rx_data", g), data_w[g], e.d);
              chk($sformatf("lane%0d_rx_ready", g), rdy_w[g], e.r);
              chk($sformatf("lane%0d_frame_err", g), ferr_w[g], e.f);
              chk($sformatf("lane%0d_parity_err", g), perr_w[g], e.p);
              chk($sformatf("lane%0d_overrun", g), ovr_w[g], e.o);
              chk($sformatf("lane%0d_busy_cycles", g), dur, e.dur);
            end
            dur = 0;
          end
          prev = busy_w[g];
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(int l, int dur);
    exp_t e;
    e.d = m_data[l]; e.r = m_rdy[l]; e.f = m_ferr[l]; e.p = m_perr[l]; e.o = m_ovr[l];
    e.dur = dur;
    exp_q[l].push_back(e);
  endtask

  task automatic send(int l, logic [7:0] d, bit stop, bit pbit);
    logic [10:0] bits;
    int nb;
    if (m_rdy[l]) m_ovr[l] = 1'b1;
    m_rdy[l]  = 1'b1;
    m_data[l] = d;
    m_ferr[l] = !stop;
    m_perr[l] = (l == 1) ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
    push_exp(l, (10 + l) * N);
    nb       = 10 + l;
    bits     = 11'h7ff;
    bits[0]  = 1'b0;
    bits[8:1] = d;
    if (l == 1) begin
      bits[9]  = pbit;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    for (int i = 0; i < nb; i++) begin
      rx_line[l] = bits[i];
      cycles(N);
    end
    rx_line[l] = 1'b1;
    cycles(15);
  endtask

  task automatic glitch(int l);
    push_exp(l, N);
    rx_line[l] = 1'b0;
    cycles(3);
    rx_line[l] = 1'b1;
    cycles(20);
  endtask

  task automatic do_ack(int l);
    ack[l]   = 1'b1;
    m_rdy[l] = 1'b0;
    m_ovr[l] = 1'b0;
    cycles(1);
    ack[l] = 1'b0;
    chk($sformatf("lane%0d_ack_ready", l), rdy_w[l], 0);
    chk($sformatf("lane%0d_ack_overrun", l), ovr_w[l], 0);
  endtask

  task automatic chk_reset(string tag);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_busy%0d", tag, l), busy_w[l], 0);
      chk($sformatf("%s_bit_en%0d", tag, l), bit_en_w[l], 0);
      chk($sformatf("%s_data%0d", tag, l), data_w[l], 0);
      chk($sformatf("%s_ready%0d", tag, l), rdy_w[l], 0);
      chk($sformatf("%s_ferr%0d", tag, l), ferr_w[l], 0);
      chk($sformatf("%s_perr%0d", tag, l), perr_w[l], 0);
      chk($sformatf("%s_ovr%0d", tag, l), ovr_w[l], 0);
    end
  endtask

  task automatic model_reset();
    m_rdy = '0; m_ovr = '0; m_ferr = '0; m_perr = '0;
    m_data[0] = 8'h00;
    m_data[1] = 8'h00;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] part;
    model_reset();
    cycles(3);
    chk_reset("reset");
    rst = 1'b1;
    cycles(5);

    send(0, 8'hA5, 1'b1, 1'b0);
    do_ack(0);
    glitch(0);
    send(0, 8'h3C, 1'b0, 1'b0);
    send(0, 8'hC3, 1'b1, 1'b0);
    do_ack(0);
    send(0, 8'h11, 1'b1, 1'b0);
    send(0, 8'h22, 1'b1, 1'b0);
    chk("overrun_after_two", ovr_w[0], 1);
    do_ack(0);

    send(1, 8'h07, 1'b1, 1'b0);
    send(1, 8'h07, 1'b1, 1'b1);
    do_ack(1);
    glitch(1);

    // Abort lane 0 mid data bit 4 with a reset; outputs are non-zero beforehand.
    send(0, 8'hFF, 1'b0, 1'b0);
    part = 8'h96;
    rx_line[0] = 1'b0;
    cycles(N);
    for (int i = 0; i < 4; i++) begin
      rx_line[0] = part[i];
      cycles(N);
    end
    rx_line[0] = part[4];
    cycles(5);
    rst = 1'b0;
    model_reset();
    cycles(2);
    rx_line[0] = 1'b1;
    chk_reset("midframe_reset");
    rst = 1'b1;
    cycles(20);
    send(0, 8'h5A, 1'b1, 1'b0);
    do_ack(0);

    for (int k = 0; k < 30; k++) begin
      int l;
      int r;
      l = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      if (r == 0) glitch(l);
      else send(l, 8'($urandom), r != 1, 1'($urandom));
      if ($urandom_range(0, 2) == 0) do_ack(l);
    end

    cycles(20);
    chk("lane0_queue_drained", exp_q[0].size(), 0);
    chk("lane1_queue_drained", exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
